timer_entrada_param: RTL and testbench
======================================

Name: timer_entrada_param

Overview:
Parametrised keypad front-end for the timer path. It priority-encodes an N_KEYS one-hot/multi-hot key vector, debounces press and release, emits one validated BCD digit per physical press, and accumulates the digits into an N_DIGITS BCD entry register. It also generates the timebase tick, which is muxed with entry-strobe pulses according to mode. Sits between the keypad pins and the timer counter/load logic.

Parameters:
N_KEYS, 10, number of key inputs; key[i] encodes digit i (max 10).
N_DIGITS, 4, BCD digits held in entry register.
DEBOUNCE_CYCLES, 5, consecutive stable clk100 cycles needed to accept a press or release (>=1).
CLK_HZ, 100, clk100 frequency.
TICK_HZ, 1, tick rate; DIV = CLK_HZ/TICK_HZ must be an integer >= 2.

Ports:
clk100  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
key  in  N_KEYS  raw key levels, active-high, asynchronous to clk100 (2-flop synchronised internally).
entry_en  in  1  1 = entry mode (keys accepted), 0 = run mode (keys ignored).
clear_digits  in  1  synchronous clear of entry register.
digit  out  4  BCD code of last accepted key.
digit_valid  out  1  one-cycle strobe per accepted press.
digits  out  4*N_DIGITS  entry register; digit 0 in bits [3:0] (least significant).
key_held  out  1  high while a debounced press is held.
tick  out  1  one-cycle pulse: timebase tick (run mode) or digit_valid (entry mode).

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM IDLE, debounce and divider counters 0, synchroniser flops 0.
- Encoding: code = highest asserted index of synchronised key; none asserted = "no key".
- FSM on synchronised key, count = debounce counter:
  - IDLE: no key -> stay. Key present and entry_en=1 -> PRESS_DB, latch code, count=1.
  - PRESS_DB: same code -> count++; when count reaches DEBOUNCE_CYCLES -> HELD, digit=code, digit_valid=1 for that cycle. Different nonzero code -> relatch, count=1. No key -> IDLE.
  - HELD: key_held=1. No key -> REL_DB, count=1. Any key (including a code change) -> stay; no repeat or second strobe.
  - REL_DB: no key -> count++; at DEBOUNCE_CYCLES -> IDLE. Any key -> HELD.
  - entry_en=0 in any state -> IDLE next cycle; no strobe.
- Latency: press applied at cycle 0 -> digit_valid at cycle 2 (sync) + DEBOUNCE_CYCLES.
- Entry register: on digit_valid, digits <= {digits[4*N_DIGITS-5:0], digit}; MSD discarded on overflow.
- clear_digits: digits <= 0 next cycle. If it coincides with digit_valid, clear wins and the digit is dropped. digit is unaffected.
- Divider: counter 0..DIV-1 free-running while entry_en=0; tick=1 when counter==DIV-1, then wrap to 0. While entry_en=1, counter held at 0, so the first run-mode tick comes exactly DIV cycles after entry_en falls.
- tick = entry_en ? digit_valid : divider pulse. Registered; no glitch on the mode switch.
- digit holds its value until the next accepted press; it is never cleared except by rst.

Decomposition:
- Shared package timer_pkg: FSM state encoding (IDLE, PRESS_DB, HELD, REL_DB), BCD width constant 4, NO_KEY sentinel.
- One natural sub-module: div_tick_param (parametrised DIV counter with hold input, one-cycle tick). Encoder, debounce FSM and shift register stay inline.

Test Plan:
1. DEBOUNCE_CYCLES=3, entry_en=1, key=10'b0000100000 held for 10 cycles -> exactly one digit_valid, 5 cycles after assertion, with digit=5 and digits=16'h0005; tick pulses with it.
2. Press sequence 1,2,3,4,5 (each held 8 cycles and released 8 cycles) -> digits=16'h2345, five strobes total.
3. Bounce: key toggles 1,0,1,0 each cycle, then held -> no strobe until 3 stable cycles; a single strobe with digit=1. Release bounce while HELD -> no extra strobe.
4. key=10'b1000000100 -> digit=9. Changing to key 2 while HELD -> no new strobe.
5. entry_en=0, CLK_HZ=100 -> tick every 100 cycles, first tick at cycle 100 after entry_en falls; key presses ignored and digits unchanged.
6. rst asserted mid-PRESS_DB and while HELD with digits=16'h0012 -> all outputs 0 immediately (async). clear_digits asserted on the strobe cycle -> digits=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer keypad front-end: debounce FSM states,
// BCD digit width and the "no key pressed" encoder sentinel.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  localparam int BCD_W = 4;

  // Never a legal digit code because at most ten keys exist.
  localparam logic [BCD_W-1:0] NO_KEY = 4'hF;

endpackage

// File: rtl/timer_entrada_param_div_tick.sv
// Free-running modulo-DIV counter producing a one-cycle terminal-count pulse;
// the hold input parks the counter at zero.
module div_tick_param #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic pulse
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (hold || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Combinational so the parent can register it alongside the entry strobe.
  assign pulse = !hold && (count == LAST);

endmodule

// File: rtl/timer_entrada_param.sv
// Keypad front-end: synchronises and priority-encodes keys, debounces press and
// release, shifts accepted BCD digits into the entry register and muxes the tick.
module timer_entrada_param
  import timer_pkg::*;
#(
  parameter int N_KEYS          = 10,
  parameter int N_DIGITS        = 4,
  parameter int DEBOUNCE_CYCLES = 5,
  parameter int CLK_HZ          = 100,
  parameter int TICK_HZ         = 1
) (
  input  logic                      clk100,
  input  logic                      rst,
  input  logic [N_KEYS-1:0]         key,
  input  logic                      entry_en,
  input  logic                      clear_digits,
  output logic [BCD_W-1:0]          digit,
  output logic                      digit_valid,
  output logic [BCD_W*N_DIGITS-1:0] digits,
  output logic                      key_held,
  output logic                      tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DW    = BCD_W * N_DIGITS;
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] key_s1;
  logic [N_KEYS-1:0] key_s2;
  logic [BCD_W-1:0]  code;
  logic              present;
  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [BCD_W-1:0]  latched;
  logic              strobe;
  logic              div_pulse;

  // Highest asserted index wins.
  always_comb begin
    code = NO_KEY;
    for (int i = 0; i < N_KEYS; i++) begin
      if (key_s2[i]) begin
        code = BCD_W'(i);
      end
    end
  end

  assign present = (code != NO_KEY);

  // With a single-cycle debounce the press is accepted straight from IDLE.
  assign strobe = entry_en && present &&
                  ((state == IDLE && DEBOUNCE_CYCLES == 1) ||
                   (state == PRESS_DB && code == latched && count == CNT_LAST));

  div_tick_param #(
    .DIV(DIV)
  ) u_div (
    .clk  (clk100),
    .rst  (rst),
    .hold (entry_en),
    .pulse(div_pulse)
  );

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      key_s1      <= '0;
      key_s2      <= '0;
      state       <= IDLE;
      count       <= '0;
      latched     <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      key_held    <= 1'b0;
      tick        <= 1'b0;
    end else begin
      key_s1      <= key;
      key_s2      <= key_s1;
      digit_valid <= strobe;
      tick        <= entry_en ? strobe : div_pulse;
      if (strobe) begin
        digit <= code;
      end
      if (!entry_en) begin
        state    <= IDLE;
        count    <= '0;
        key_held <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (present) begin
              latched <= code;
              if (strobe) begin
                state    <= HELD;
                key_held <= 1'b1;
              end else begin
                state <= PRESS_DB;
                count <= CNT_W'(1);
              end
            end
          end
          PRESS_DB: begin
            if (!present) begin
              state <= IDLE;
              count <= '0;
            end else if (code != latched) begin
              latched <= code;
              count   <= CNT_W'(1);
            end else if (strobe) begin
              state    <= HELD;
              count    <= '0;
              key_held <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
          HELD: begin
            // Code changes while held are deliberately ignored: no auto-repeat.
            if (!present) begin
              key_held <= 1'b0;
              if (DEBOUNCE_CYCLES == 1) begin
                state <= IDLE;
              end else begin
                state <= REL_DB;
                count <= CNT_W'(1);
              end
            end
          end
          REL_DB: begin
            if (present) begin
              state    <= HELD;
              count    <= '0;
              key_held <= 1'b1;
            end else if (count == CNT_LAST) begin
              state <= IDLE;
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

  // Clear has priority over a coincident digit, which is then lost.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      digits <= '0;
    end else if (clear_digits) begin
      digits <= '0;
    end else if (digit_valid) begin
      digits <= (digits << BCD_W) | DW'(digit);
    end
  end

endmodule

// File: tb/tb_timer_entrada_param.sv
// Self-checking bench: directed scenarios plus random key/mode traffic compared
// cycle by cycle against a run-length reference model of the keypad front-end.
module tb_timer_entrada_param;

  localparam int NK  = 10;
  localparam int ND  = 4;
  localparam int DB  = 3;
  localparam int DIV = 100;

  logic          clk100 = 1'b0;
  logic          rst;
  logic [NK-1:0] key;
  logic          entry_en;
  logic          clear_digits;
  logic [3:0]    digit;
  logic          digit_valid;
  logic [15:0]   digits;
  logic          key_held;
  logic          tick;

  timer_entrada_param #(
    .N_KEYS(NK), .N_DIGITS(ND), .DEBOUNCE_CYCLES(DB), .CLK_HZ(100), .TICK_HZ(1)
  ) dut (
    .clk100(clk100), .rst(rst), .key(key), .entry_en(entry_en),
    .clear_digits(clear_digits), .digit(digit), .digit_valid(digit_valid),
    .digits(digits), .key_held(key_held), .tick(tick)
  );

  always #5 clk100 = ~clk100;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edge_cnt);
    end
  endtask

  function automatic int enc(input logic [NK-1:0] k);
    int r;
    r = 15;
    for (int i = 0; i < NK; i++) if (k[i]) r = i;
    return r;
  endfunction

  // Reference model: press accepted after DB consecutive identical samples,
  // release after DB consecutive empty samples; keys reach it 2 edges late.
  int          edge_cnt = 0;
  logic [NK-1:0] m_ks1, m_ks2;
  int          m_code, m_last, m_run, m_rrun, m_phase;
  bit          m_heldst, m_fire, m_strobe;
  logic [3:0]  m_digit;
  logic [15:0] m_digits;
  bit          m_dv, m_tick, m_key_held;

  always @(posedge clk100 or posedge rst) begin
    if (rst) begin
      m_ks1 = '0; m_ks2 = '0; m_run = 0; m_rrun = 0; m_last = 15; m_phase = 0;
      m_heldst = 0; m_digit = 0; m_digits = 0; m_dv = 0; m_tick = 0; m_key_held = 0;
    end else begin
      edge_cnt++;
      m_code = enc(m_ks2);
      if (entry_en) m_phase = 0; else m_phase++;
      m_fire = !entry_en && (m_phase % DIV == 0);
      m_strobe = 0;
      if (!entry_en) begin
        m_heldst = 0; m_run = 0; m_rrun = 0;
      end else if (!m_heldst) begin
        if (m_code == 15) m_run = 0;
        else if (m_run > 0 && m_code == m_last) m_run++;
        else begin m_run = 1; m_last = m_code; end
        if (m_run == DB) begin m_heldst = 1; m_strobe = 1; m_run = 0; m_rrun = 0; end
      end else begin
        if (m_code == 15) begin
          m_rrun++;
          if (m_rrun == DB) begin m_heldst = 0; m_rrun = 0; m_run = 0; end
        end else m_rrun = 0;
      end
      if (clear_digits) m_digits = 0;
      else if (m_dv) m_digits = {m_digits[11:0], m_digit};
      if (m_strobe) m_digit = 4'(m_code);
      m_dv = m_strobe;
      m_tick = entry_en ? m_strobe : m_fire;
      m_key_held = m_heldst && (m_rrun == 0);
      m_ks2 = m_ks1;
      m_ks1 = key;
    end
  end

  int dv_count = 0;
  int last_dv_edge = -1;
  int tick_count = 0;
  int first_tick_edge = -1;

  always @(negedge clk100) begin
    if (!rst) begin
      check("digit_valid", 32'(digit_valid), 32'(m_dv));
      check("digit", 32'(digit), 32'(m_digit));
      check("digits", 32'(digits), 32'(m_digits));
      check("key_held", 32'(key_held), 32'(m_key_held));
      check("tick", 32'(tick), 32'(m_tick));
      if (digit_valid) begin
        dv_count++;
        last_dv_edge = edge_cnt;
        $display("edge %0d: digit %0d accepted, digits=%h", edge_cnt, digit, digits);
      end
      if (tick && !entry_en) begin
        tick_count++;
        if (first_tick_edge < 0) first_tick_edge = edge_cnt;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic press(input int k, input int hold, input int gap);
    key = '0; key[k] = 1'b1;
    cyc(hold);
    key = '0;
    cyc(gap);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digit"}, 32'(digit), 0);
    check({tag, "_dv"}, 32'(digit_valid), 0);
    check({tag, "_digits"}, 32'(digits), 0);
    check({tag, "_held"}, 32'(key_held), 0);
    check({tag, "_tick"}, 32'(tick), 0);
  endtask

  int t0, base, r;

  initial begin
    rst = 1'b1; key = '0; entry_en = 1'b1; clear_digits = 1'b0;
    cyc(2);
    check_zero("reset");
    rst = 1'b0;
    cyc(3);

    // Single clean press of key 5
    base = dv_count; t0 = edge_cnt;
    key = 10'b0000100000;
    cyc(10);
    key = '0;
    cyc(10);
    check("t1_strobes", 32'(dv_count - base), 1);
    check("t1_latency", 32'(last_dv_edge - t0), 5);
    check("t1_digit", 32'(digit), 5);
    check("t1_digits", 32'(digits), 32'h0005);

    // Sequence 1..5
    base = dv_count;
    for (int i = 1; i <= 5; i++) press(i, 8, 8);
    check("t2_strobes", 32'(dv_count - base), 5);
    check("t2_digits", 32'(digits), 32'h2345);

    // Press and release bounce on key 1
    base = dv_count;
    for (int i = 0; i < 4; i++) begin key = (i % 2 == 0) ? 10'b10 : 10'b0; cyc(1); end
    key = 10'b10;
    cyc(10);
    for (int i = 0; i < 5; i++) begin key = (i % 2 == 0) ? 10'b0 : 10'b10; cyc(1); end
    key = '0;
    cyc(10);
    check("t3_strobes", 32'(dv_count - base), 1);
    check("t3_digit", 32'(digit), 1);

    // Multi-hot priority, then code change while held
    base = dv_count;
    key = 10'b1000000100;
    cyc(8);
    key = 10'b0000000100;
    cyc(8);
    key = '0;
    cyc(10);
    check("t4_strobes", 32'(dv_count - base), 1);
    check("t4_digit", 32'(digit), 9);
    check("t4_digits", 32'(digits), 32'h4519);

    // Run mode: timebase ticks, keys ignored
    base = dv_count; tick_count = 0; first_tick_edge = -1;
    entry_en = 1'b0; t0 = edge_cnt;
    cyc(30);
    press(7, 10, 10);
    cyc(200);
    check("t5_first_tick", 32'(first_tick_edge - t0), DIV);
    check("t5_tick_count", 32'(tick_count), 2);
    check("t5_strobes", 32'(dv_count - base), 0);
    check("t5_digits", 32'(digits), 32'h4519);
    entry_en = 1'b1;
    cyc(3);

    // Async reset mid-PRESS_DB and while HELD
    clear_digits = 1'b1; cyc(1); clear_digits = 1'b0;
    press(1, 8, 8);
    key = 10'b100;
    cyc(3);
    rst = 1'b1; #1;
    check_zero("rst_pressdb");
    cyc(1); rst = 1'b0; key = '0; cyc(3);
    press(1, 8, 8);
    press(2, 8, 8);
    check("t6_digits", 32'(digits), 32'h0012);
    key = 10'b1000;
    cyc(8);
    check("t6_held", 32'(key_held), 1);
    #2; rst = 1'b1; #1;
    check_zero("rst_held");
    cyc(1); rst = 1'b0; key = '0; cyc(3);

    // Clear coinciding with the strobe drops the digit
    press(6, 8, 8);
    t0 = edge_cnt;
    key = 10'b10000000;
    cyc(5);
    check("t6_strobe_now", 32'(digit_valid), 1);
    clear_digits = 1'b1; cyc(1); clear_digits = 1'b0;
    check("t6_clear_win", 32'(digits), 0);
    check("t6_digit_kept", 32'(digit), 7);
    key = '0;
    cyc(10);

    // Random traffic against the model
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) entry_en = ~entry_en;
      clear_digits = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 9);
      if (r < 3) key = '0;
      else if (r < 8) begin key = '0; key[$urandom_range(0, NK - 1)] = 1'b1; end
      else key = NK'($urandom);
      cyc($urandom_range(1, 8));
      clear_digits = 1'b0;
    end
    key = '0;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
